counter_bank_drain: RTL and testbench

- Bank of DEPTH counters held in a register array.
- Increment side: one in-place read-modify-write per cycle (mem[addr] <= mem[addr]+1).
- Drain side: on request, walks every entry in order, presents each as a valid/ready stream beat, and clears the entry as it is captured.
- Sits between event-counting logic (writer) and a host/readout path (reader).

---
 rtl/counter_bank_pkg.sv | 26 ++
 rtl/counter_bank_mem.sv | 50 +++++
 rtl/counter_bank_drain.sv | 98 +++++++++
 tb/tb_counter_bank_drain.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter bank with drain stream.
// COUNTER_BANK_SATURATE_EN selects saturating instead of wrapping counters.
package counter_bank_pkg;

  localparam int unsigned DefaultAddrW = 3;
  localparam int unsigned DefaultDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend
  } drain_state_t;

  // Next counter value for a counter of the given width (width <= 64).
  function automatic logic [63:0] next_count(logic [63:0] val, int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
`ifdef COUNTER_BANK_SATURATE_EN
    if (val == max_val) begin
      return max_val;
    end
`endif
    return (val + 64'd1) & max_val;
  endfunction

endpackage

// File: rtl/counter_bank_mem.sv
// Counter register array: increment port, clear port and async read port.
// A clear that collides with an increment of the same entry leaves it at 1.
module counter_bank_mem
  import counter_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_valid_i,
  input  logic [ADDR_W-1:0] inc_addr_i,
  input  logic              clr_valid_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (inc_valid_i && (inc_addr_i == ADDR_W'(i))) begin
        mem_d[i] = DATA_W'(next_count(64'(mem_q[i]), DATA_W));
      end
      if (clr_valid_i && (clr_addr_i == ADDR_W'(i))) begin
        // The captured value excludes this cycle's increment, so keep it here.
        mem_d[i] = (inc_valid_i && (inc_addr_i == clr_addr_i)) ? DATA_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/counter_bank_drain.sv
// Counter bank with a read-and-clear drain pass presented as a valid/ready stream.
// Counter overflow behaviour follows COUNTER_BANK_SATURATE_EN (see counter_bank_pkg).
module counter_bank_drain
  import counter_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_valid,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              drain_start,
  output logic              drain_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  drain_state_t      state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              valid_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_data;
  logic              load;

  assign load = (state_q == StLoad);

  counter_bank_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .inc_valid_i (inc_valid),
    .inc_addr_i  (inc_addr),
    .clr_valid_i (load),
    .clr_addr_i  (idx_q),
    .rd_addr_i   (idx_q),
    .rd_data_o   (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (drain_start) begin
            state_q <= StLoad;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          data_q  <= rd_data;
          addr_q  <= idx_q;
          last_q  <= (idx_q == ADDR_W'(DEPTH - 1));
          valid_q <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign drain_busy = busy_q;
  assign out_valid  = valid_q;
  assign out_addr   = addr_q;
  assign out_data   = data_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_counter_bank_drain.sv
// Self-checking bench for counter_bank_drain: behavioural model plus directed
// and random stimulus; a narrow second instance exercises counter overflow.
module tb_counter_bank_drain;

  localparam int unsigned AW = 3;
  localparam int unsigned DP = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          inc_valid, drain_start, out_ready;
  logic [AW-1:0] inc_addr;
  logic          drain_busy, out_valid, out_last;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  logic          n_inc_valid, n_drain_start, n_out_ready;
  logic [AW-1:0] n_inc_addr;
  logic          n_drain_busy, n_out_valid, n_out_last;
  logic [AW-1:0] n_out_addr;
  logic [NW-1:0] n_out_data;

  always #5 clk = ~clk;

  counter_bank_drain #(.ADDR_W(AW), .DEPTH(DP), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .inc_valid(inc_valid), .inc_addr(inc_addr),
    .drain_start(drain_start), .drain_busy(drain_busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  counter_bank_drain #(.ADDR_W(AW), .DEPTH(DP), .DATA_W(NW)) dut_n (
    .clk(clk), .reset_n(reset_n), .inc_valid(n_inc_valid), .inc_addr(n_inc_addr),
    .drain_start(n_drain_start), .drain_busy(n_drain_busy), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .out_addr(n_out_addr), .out_data(n_out_data),
    .out_last(n_out_last)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: counter values plus the visible drain stream.
  logic [DW-1:0] m_cnt [DP];
  bit            m_busy, m_loading, m_valid, m_last;
  int            m_idx;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Beats actually taken from the DUT during a pass.
  logic [DW-1:0] seen [DP];
  int            beats, lasts;
  logic [AW-1:0] last_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] inc_val(input logic [DW-1:0] v);
`ifdef COUNTER_BANK_SATURATE_EN
    return (v == {DW{1'b1}}) ? v : v + 1;
`else
    return v + 1;
`endif
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = '0;
    m_busy = 0; m_loading = 0; m_valid = 0; m_last = 0;
    m_idx = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic clear_seen();
    foreach (seen[i]) seen[i] = 32'hDEAD_BEEF;
    beats = 0; lasts = 0; last_addr = '0;
  endtask

  // Advance the model by one clock given the inputs currently driven.
  task automatic model_step();
    logic [DW-1:0] nxt [DP];
    bit cap, hs;
    cap = m_loading;
    hs  = m_valid && out_ready;
    if (hs) begin
      beats++;
      seen[out_addr] = out_data;
      if (out_last) begin
        lasts++;
        last_addr = out_addr;
      end
    end
    foreach (m_cnt[i]) nxt[i] = m_cnt[i];
    if (cap) begin
      m_data = m_cnt[m_idx];
      m_addr = AW'(m_idx);
      m_last = (m_idx == DP - 1);
      nxt[m_idx] = '0;
    end
    if (inc_valid) begin
      nxt[inc_addr] = (cap && int'(inc_addr) == m_idx) ? DW'(1) : inc_val(m_cnt[inc_addr]);
    end
    m_cnt = nxt;
    if (cap) begin
      m_loading = 0;
      m_valid = 1;
    end else if (hs) begin
      m_valid = 0;
      if (m_last) m_busy = 0;
      else begin
        m_idx++;
        m_loading = 1;
      end
    end else if (!m_busy && drain_start) begin
      m_busy = 1;
      m_idx = 0;
      m_loading = 1;
    end
  endtask

  task automatic compare();
    chk("drain_busy", drain_busy, m_busy);
    chk("out_valid", out_valid, m_valid);
    chk("out_addr", out_addr, m_addr);
    chk("out_data", out_data, m_data);
    chk("out_last", out_last, m_last);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic inc_n(input int addr, input int n);
    for (int k = 0; k < n; k++) begin
      inc_valid = 1; inc_addr = AW'(addr); drain_start = 0; out_ready = 1;
      tick();
    end
    inc_valid = 0;
  endtask

  // mode 0 plain, 1 collision on idx 2, 2 stall on beat 0, 3 re-pulse drain_start
  task automatic drain_pass(input int mode, output int stalls);
    int n;
    stalls = 0;
    clear_seen();
    inc_valid = 0; out_ready = 1; drain_start = 1;
    tick();
    drain_start = 0;
    n = 0;
    while (m_busy && n < 80) begin
      inc_valid = 0; out_ready = 1; drain_start = 0;
      case (mode)
        1: begin
          inc_valid = m_loading && m_idx == 2;
          inc_addr = 3'd2;
        end
        2: begin
          if (m_valid && m_addr == 0 && stalls < 10) begin
            out_ready = 0;
            inc_valid = 1;
            inc_addr = (stalls % 2 == 0) ? 3'd0 : 3'd4;
            stalls++;
          end
        end
        3: drain_start = 1'($urandom_range(0, 1));
        default: ;
      endcase
      tick();
      n++;
    end
    if (n >= 80) chk("drain_timeout", 1, 0);
    inc_valid = 0; drain_start = 0; out_ready = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, cnt;
    logic [NW-1:0] n_data;
    bit got;

    reset_n = 0; inc_valid = 0; inc_addr = '0; drain_start = 0; out_ready = 1;
    n_inc_valid = 0; n_inc_addr = '0; n_drain_start = 0; n_out_ready = 1;
    model_reset();
    clear_seen();
    repeat (2) @(negedge clk);
    compare();
    reset_n = 1;

    // Basic pass: addr 3 counts 5, everything else 0.
    inc_n(3, 5);
    drain_pass(0, stalls);
    chk("p1_beats", beats, 8);
    chk("p1_addr3", seen[3], 5);
    chk("p1_addr0", seen[0], 0);
    chk("p1_addr7", seen[7], 0);
    chk("p1_lasts", lasts, 1);
    chk("p1_last_addr", last_addr, 7);
    drain_pass(0, stalls);
    cnt = 0;
    foreach (seen[i]) if (seen[i] != 0) cnt++;
    chk("p1_cleared", cnt, 0);

    // Collision: increment lands on the capture cycle of entry 2.
    inc_n(2, 3);
    drain_pass(1, stalls);
    chk("coll_pre", seen[2], 3);
    drain_pass(0, stalls);
    chk("coll_next", seen[2], 1);

    // Backpressure on beat 0 while counting entries 0 and 4.
    inc_n(0, 2);
    inc_n(4, 1);
    drain_pass(2, stalls);
    chk("stall_cycles", stalls, 10);
    chk("stall_addr0", seen[0], 2);
    chk("stall_addr4", seen[4], 6);
    drain_pass(0, stalls);
    chk("stall_next0", seen[0], 5);
    chk("stall_next4", seen[4], 0);

    // drain_start re-pulsed during a pass.
    inc_n(6, 4);
    drain_pass(3, stalls);
    chk("repulse_beats", beats, 8);
    chk("repulse_addr6", seen[6], 4);

    // Reset in the middle of a pass, while beat 3 is held.
    inc_n(5, 2);
    inc_valid = 0; out_ready = 1; drain_start = 1;
    tick();
    drain_start = 0;
    cnt = 0;
    while (!(m_valid && m_addr == 3) && cnt < 40) begin
      tick();
      cnt++;
    end
    out_ready = 0;
    tick();
    reset_n = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", drain_busy, 0);
    chk("rst_data", out_data, 0);
    model_reset();
    @(negedge clk);
    compare();
    reset_n = 1;
    out_ready = 1;
    drain_pass(0, stalls);
    cnt = 0;
    foreach (seen[i]) if (seen[i] != 0) cnt++;
    chk("rst_all_zero", cnt, 0);
    chk("rst_beats", beats, 8);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      inc_valid = 1'($urandom_range(0, 1));
      inc_addr = AW'($urandom_range(0, DP - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      drain_start = ($urandom_range(0, 7) == 0);
      tick();
    end
    inc_valid = 0; drain_start = 0; out_ready = 1;

    // Narrow instance: 16 increments of a 4-bit counter.
    for (int k = 0; k < 16; k++) begin
      n_inc_valid = 1; n_inc_addr = 3'd1;
      @(negedge clk);
    end
    n_inc_valid = 0;
    n_drain_start = 1;
    @(negedge clk);
    n_drain_start = 0;
    got = 0; n_data = '0;
    for (int k = 0; k < 40; k++) begin
      if (n_out_valid && n_out_addr == 3'd1) begin
        got = 1;
        n_data = n_out_data;
      end
      @(negedge clk);
    end
    chk("narrow_beat", got, 1);
`ifdef COUNTER_BANK_SATURATE_EN
    chk("narrow_overflow", n_data, 4'hF);
`else
    chk("narrow_overflow", n_data, 4'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
